// File: rtl/reg_writeback_arbiter.sv
// Write-port master for the GPR file: merges single-cycle ALU results with
// FIFO-buffered load results and drives the registered write port.
module reg_writeback_arbiter #(
    parameter int REG_FILE_BITS = 5,
    parameter int REG_SIZE      = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_FILE_BITS-1:0]      alu_rd,
    input  logic [REG_SIZE-1:0]           alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REG_FILE_BITS-1:0]      mem_rd,
    input  logic [REG_SIZE-1:0]           mem_data,
    output logic                          we,
    output logic [REG_FILE_BITS-1:0]      write_num,
    output logic [REG_SIZE-1:0]           to_write_data,
    output logic [(1<<REG_FILE_BITS)-1:0] pending_mask
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      we_q, we_d;
    logic [REG_FILE_BITS-1:0]  num_q, num_d;
    logic [REG_SIZE-1:0]       wdata_q, wdata_d;
    logic [REG_FILE_BITS-1:0]  fifo_rd_q   [FIFO_DEPTH];
    logic [REG_SIZE-1:0]       fifo_data_q [FIFO_DEPTH];

    logic                      full, empty, enq, deq, sel_valid;
    logic [REG_FILE_BITS-1:0]  sel_rd;
    logic [REG_SIZE-1:0]       sel_data;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign mem_ready = !full;
    assign alu_ready = (state_q != DRAIN);
    assign enq       = mem_valid && !full;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        deq       = 1'b0;
        sel_valid = 1'b0;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        unique case (state_q)
            DRAIN: begin
                deq      = 1'b1;
                starve_d = '0;
                state_d  = NORMAL;
            end
            NORMAL: begin
                if (alu_valid) begin
                    sel_valid = 1'b1;
                    if (!empty) begin
                        starve_d = starve_q + SW'(1);
                        if (starve_d == SW'(STARVE_LIMIT)) state_d = DRAIN;
                    end
                end else if (!empty) begin
                    deq      = 1'b1;
                    starve_d = '0;
                end
            end
        endcase
        if (deq) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd_q[head_q];
            sel_data  = fifo_data_q[head_q];
        end
    end

    always_comb begin
        // x0 entries are consumed but never written
        we_d    = sel_valid && (sel_rd != '0);
        num_d   = sel_valid ? sel_rd : num_q;
        wdata_d = sel_valid ? sel_data : wdata_q;
        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < count_q) pending_mask[fifo_rd_q[head_q + PW'(i)]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NORMAL;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            num_q    <= '0;
            wdata_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            num_q    <= num_d;
            wdata_q  <= wdata_d;
            if (enq) begin
                fifo_rd_q[tail_q]   <= mem_rd;
                fifo_data_q[tail_q] <= mem_data;
            end
        end
    end

    assign we            = we_q;
    assign write_num     = num_q;
    assign to_write_data = wdata_q;

endmodule
